sha256_msg_padder: RTL
======================

Name: sha256_msg_padder

Overview:
- Upstream stage of sha256_processing; converts software-written 32-bit message words into complete SHA-256 padded 512-bit blocks.
- Sits between the AXI-lite register bank (ctrl_signals, string_i) and the compression core.
- Appends 0x80, zero fill and the 64-bit big-endian bit length.
- Emits 1 or 2 blocks per final word, with a valid/ready handshake.

Parameters:
CNT_W, 61, width of internal message byte counter; bit length = byte count << 3, zero-extended to 64.

Ports:
axi_clk_i  in  1  clock
aresetn_i  in  1  asynchronous active-low reset
ctrl_signals  in  32  [31]=word strobe (level, held many cycles), [30]=last word, [3:0]=keep, rest ignored
string_i  in  32  message word; byte0=[31:24]
block_o  out  512  padded block; word0=[511:480] … word15=[31:0]
block_valid_o  out  1  block_o valid
block_ready_i  in  1  downstream accepts block
block_final_o  out  1  block is last of message (qualified by valid)
busy_o  out  1  state != FILL
err_o  out  1  sticky error (see Optional Feature)

Behaviour:
- One clock; aresetn_i async-clears all state. Outputs after reset: block_o=0, block_valid_o=0, block_final_o=0, busy_o=0, err_o=0, state=FILL, ptr=0, byte count=0, pend80=0.
- Reset mid-operation discards partial message and any pending block; no block emitted.
- Strobe detect:
  - stb_q registers ctrl_signals[31].
  - Word event = ctrl_signals[31] & ~stb_q, sampled at the edge.
  - Exactly one event per 0→1 transition, regardless of hold length.
- Keep is MSB-contiguous: legal 1111, 1110, 1100, 1000; 0000 legal only with last. Valid bytes are the upper bytes.
- Buffer: 16x32, write pointer ptr 0..15; all words cleared to 0 on each accepted handshake.
- States:
  - FILL:
    - Event, not last: store word at ptr, count+=4, ptr++.
    - If ptr was 15 → SEND with final=0.
  - FILL, event with last:
    - Store masked bytes; invalid bytes forced 0; count += popcount(keep).
    - keep≠1111: 0x80 placed in first invalid byte of the same word; k=ptr.
    - keep=1111: 0x80 goes to byte0 of word ptr+1; k=ptr+1. If ptr=15, set pend80 and k=16.
    - → LEN.
  - LEN (one cycle):
    - k≤13: write bit length hi→word14, lo→word15; → SEND final=1.
    - 14≤k≤15: → SEND final=0, set lenpend.
    - k=16: → SEND final=0, set lenpend.
  - SEND: block_valid_o=1, block_o/block_final_o stable while valid.
    - On valid&ready, clear buffer; then:
      - lenpend → LEN2.
      - final → FILL with count=0, ptr=0.
      - otherwise → FILL with ptr=0.
  - LEN2 (one cycle): word0=0x80000000 if pend80; write length words 14/15; clear lenpend/pend80; → SEND final=1.
- Latency:
  - Final word captured at edge E0, padding fits → block_valid_o high after E1.
  - Second block valid 2 edges after first handshake.
- Events arriving in LEN/SEND/LEN2 are dropped (overrun); block_o unaffected.
- Simultaneous handshake and event in the same cycle: event is dropped. FILL is only entered on the following edge.
- Byte counter wraps modulo 2^CNT_W; no error.

Optional Feature:
- Macro: SHA256_PAD_ERR_EN.
- Defined:
  - err_o is set on overrun, on illegal keep, or on keep≠1111 without last.
  - Illegal word is still stored as 1111 and processing continues.
  - err_o cleared only by reset or by a final handshake.
- Undefined: err_o tied 0 and no checks made; keep treated as stated.

Test Plan:
- "abc": string_i=0x61626330, keep=1110, last → one block, word0=0x61626380, words1..14=0, word15=0x00000018, final=1; valid 2 edges after strobe edge.
- 14 full words 0x01010101, last on word13 → block A: words0..13 data, word14=0x80000000, word15=0, final=0. Block B: all 0 except word15=0x000001C0, final=1.
- 16 full words, last on word15 → block A: pure data, final=0. Block B: word0=0x80000000, word15=0x00000200, final=1.
- Strobe held 40 cycles, then second word → exactly 2 words counted. block_ready_i low 10 cycles during SEND with a strobe pulse → word dropped, block_o stable, err_o=1 (macro on) / 0 (off).
- Empty message (keep=0000, last) → word0=0x80000000, word15=0, final=1. aresetn_i low during SEND → valid drops immediately; next "abc" gives the exact first-scenario block.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs strobed 32-bit words into 512-bit padded blocks.
// Optional error tracking is enabled by defining SHA256_PAD_ERR_EN.
module sha256_msg_padder #(
  parameter int CNT_W = 61
) (
  input  logic         axi_clk_i,
  input  logic         aresetn_i,
  input  logic [31:0]  ctrl_signals,
  input  logic [31:0]  string_i,
  output logic [511:0] block_o,
  output logic         block_valid_o,
  input  logic         block_ready_i,
  output logic         block_final_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LEN  = 2'd1,
    SEND = 2'd2,
    LEN2 = 2'd3
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] k);
    popcount4 = {2'b00, k[3]} + {2'b00, k[2]} + {2'b00, k[1]} + {2'b00, k[0]};
  endfunction

  function automatic logic [2:0] lead_ones4(input logic [3:0] k);
    casez (k)
      4'b0???: lead_ones4 = 3'd0;
      4'b10??: lead_ones4 = 3'd1;
      4'b110?: lead_ones4 = 3'd2;
      4'b1110: lead_ones4 = 3'd3;
      default: lead_ones4 = 3'd4;
    endcase
  endfunction

  function automatic logic keep_legal(input logic [3:0] k, input logic last);
    case (k)
      4'b1111, 4'b1110, 4'b1100, 4'b1000: keep_legal = 1'b1;
      4'b0000:                            keep_legal = last;
      default:                            keep_legal = 1'b0;
    endcase
  endfunction

  // Zero the invalid bytes and drop the 0x80 marker into the first invalid byte.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [3:0] k);
    logic [31:0] r;
    r[31:24] = k[3] ? w[31:24] : 8'h00;
    r[23:16] = k[2] ? w[23:16] : 8'h00;
    r[15:8]  = k[1] ? w[15:8]  : 8'h00;
    r[7:0]   = k[0] ? w[7:0]   : 8'h00;
    case (lead_ones4(k))
      3'd0:    r[31:24] = 8'h80;
      3'd1:    r[23:16] = 8'h80;
      3'd2:    r[15:8]  = 8'h80;
      3'd3:    r[7:0]   = 8'h80;
      default: r        = r;
    endcase
    return r;
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [31:0]         buf_r [16];
  logic [3:0]          ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [4:0]          k_r;
  logic                pend80_r;
  logic                lenpend_r;
  logic                final_r;
  logic                valid_r;
  logic                busy_r;
  logic                stb_r;
  logic                evt_s;
  logic                last_s;
  logic [3:0]          keep_raw_s;
  logic [3:0]          keep_eff_s;
  logic [CNT_W+2:0]    bitlen_s;
  logic [63:0]         len_s;
  logic                unused_s;

  assign evt_s      = ctrl_signals[31] & ~stb_r;
  assign last_s     = ctrl_signals[30];
  assign keep_raw_s = ctrl_signals[3:0];
  assign bitlen_s   = {cnt_r, 3'b000};
  assign len_s      = 64'(bitlen_s);
  assign unused_s   = ^ctrl_signals[29:4];

`ifdef SHA256_PAD_ERR_EN
  logic keep_ok_s;
  logic err_set_s;
  logic final_hs_s;
  logic err_r;

  // An illegal keep (or partial keep on a non-last word) is handled as a full word.
  assign keep_ok_s  = keep_legal(keep_raw_s, last_s) & (last_s | (keep_raw_s == 4'b1111));
  assign keep_eff_s = keep_ok_s ? keep_raw_s : 4'b1111;
  assign err_set_s  = evt_s & ((state_r != FILL) | ~keep_ok_s);
  assign final_hs_s = (state_r == SEND) & block_ready_i & final_r;

  // Sticky error flag; a new error wins over the clearing final handshake.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else if (final_hs_s) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;
`else
  assign keep_eff_s = keep_raw_s;
  assign err_o      = 1'b0;
`endif

  // State register.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_r <= FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (evt_s) begin
          if (last_s) begin
            state_next_s = LEN;
          end else if (ptr_r == 4'd15) begin
            state_next_s = SEND;
          end else begin
            state_next_s = FILL;
          end
        end else begin
          state_next_s = FILL;
        end
      end
      LEN:  state_next_s = SEND;
      SEND: begin
        if (block_ready_i) begin
          state_next_s = lenpend_r ? LEN2 : FILL;
        end else begin
          state_next_s = SEND;
        end
      end
      LEN2:    state_next_s = SEND;
      default: state_next_s = FILL;
    endcase
  end

  // Registered handshake/status outputs and strobe history.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      stb_r   <= 1'b0;
    end else begin
      valid_r <= (state_next_s == SEND);
      busy_r  <= (state_next_s != FILL);
      stb_r   <= ctrl_signals[31];
    end
  end

  // Block buffer, byte counter and padding bookkeeping.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < 16; i++) begin
        buf_r[i] <= 32'h0000_0000;
      end
      ptr_r     <= 4'd0;
      cnt_r     <= '0;
      k_r       <= 5'd0;
      pend80_r  <= 1'b0;
      lenpend_r <= 1'b0;
      final_r   <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (evt_s) begin
            if (last_s) begin
              buf_r[ptr_r] <= pad_word(string_i, keep_eff_s);
              cnt_r        <= cnt_r + CNT_W'(popcount4(keep_eff_s));
              if (keep_eff_s == 4'b1111) begin
                // Marker spills into the next word, or into a second block.
                if (ptr_r == 4'd15) begin
                  pend80_r <= 1'b1;
                  k_r      <= 5'd16;
                end else begin
                  buf_r[ptr_r + 4'd1] <= 32'h8000_0000;
                  k_r                 <= {1'b0, ptr_r} + 5'd1;
                end
              end else begin
                k_r <= {1'b0, ptr_r};
              end
            end else begin
              buf_r[ptr_r] <= string_i;
              cnt_r        <= cnt_r + CNT_W'(3'd4);
              ptr_r        <= ptr_r + 4'd1;
              final_r      <= 1'b0;
            end
          end
        end
        LEN: begin
          if (k_r <= 5'd13) begin
            buf_r[4'd14] <= len_s[63:32];
            buf_r[4'd15] <= len_s[31:0];
            final_r      <= 1'b1;
          end else begin
            final_r   <= 1'b0;
            lenpend_r <= 1'b1;
          end
        end
        SEND: begin
          if (block_ready_i) begin
            for (int i = 0; i < 16; i++) begin
              buf_r[i] <= 32'h0000_0000;
            end
            if (!lenpend_r) begin
              ptr_r <= 4'd0;
              if (final_r) begin
                cnt_r <= '0;
              end
            end
          end
        end
        LEN2: begin
          if (pend80_r) begin
            buf_r[4'd0] <= 32'h8000_0000;
          end
          buf_r[4'd14] <= len_s[63:32];
          buf_r[4'd15] <= len_s[31:0];
          lenpend_r    <= 1'b0;
          pend80_r     <= 1'b0;
          final_r      <= 1'b1;
        end
        default: begin
          final_r <= final_r;
        end
      endcase
    end
  end

  // Flatten the buffer: word0 occupies the top 32 bits.
  always_comb begin
    block_o = 512'h0;
    for (int i = 0; i < 16; i++) begin
      block_o[511 - 32*i -: 32] = buf_r[i];
    end
  end

  assign block_valid_o = valid_r;
  assign block_final_o = final_r;
  assign busy_o        = busy_r;

endmodule
